// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver slice.
package uart_rx_pkg;

   // Receiver frame states
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE
   } rx_state_e;

   // Parity type encodings as seen on PAR_TYP
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Supported oversampling ratios
   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   // Unsupported ratios fall back to 8 so the bit-end compare always terminates.
   function automatic logic [5:0] legal_prescale(input logic [5:0] p);
      case (p)
         PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
         default:                              return PRESCALE_8;
      endcase
   endfunction

   // 2-of-3 majority vote
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_fsm_data_sampling.sv
// Mid-bit majority-vote sampler: three looks at RX_IN around the bit centre.
module data_sampling
   import uart_rx_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic [5:0] prescale,
   input  logic [5:0] edge_count,
   input  logic       enable,
   output logic       sampled_bit
);

   localparam int N_EARLY = 2;

   logic [5:0]         half_pre;
   logic [5:0]         early_edge [N_EARLY];
   logic [5:0]         last_edge;
   logic [N_EARLY-1:0] samples_reg;
   logic               sampled_bit_reg;

   assign half_pre  = prescale >> 1;
   assign last_edge = half_pre + 6'd1;

   // The first two samples are held in registers; the third is taken live
   // so the vote is registered on the same edge as the last look.
   generate
      for (genvar gi = 0; gi < N_EARLY; gi++) begin : g_early
         assign early_edge[gi] = half_pre + 6'(gi) - 6'd1;

         // Capture one early sample at its edge position
         always_ff @(posedge CLK) begin
            if (RST) begin
               samples_reg[gi] <= 1'b0;
            end else if (enable && (edge_count == early_edge[gi])) begin
               samples_reg[gi] <= RX_IN;
            end
         end
      end
   endgenerate

   // Register the vote; it holds until the next bit's last sample point
   always_ff @(posedge CLK) begin
      if (RST) begin
         sampled_bit_reg <= 1'b0;
      end else if (enable && (edge_count == last_edge)) begin
         sampled_bit_reg <= majority3(samples_reg[0], samples_reg[1], RX_IN);
      end
   end

   assign sampled_bit = sampled_bit_reg;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: frame FSM, data shifting, parity and stop checks.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            prescale,
   input  logic [5:0]            edge_count,
   input  logic [3:0]            bit_count,
   output logic                  enable,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  strt_glitch
);

   rx_state_e             state_reg;
   logic                  enable_reg;
   logic [DATA_WIDTH-1:0] p_data_reg;
   logic [DATA_WIDTH-1:0] data_shift_reg;
   logic                  data_valid_reg;
   logic                  par_err_reg;
   logic                  stp_err_reg;
   logic                  strt_glitch_reg;
   logic                  par_fail_reg;
   logic                  stop_fail_reg;
   logic                  par_en_reg;
   logic                  par_typ_reg;
   logic [5:0]            prescale_reg;

   logic                  sampled_bit;
   logic                  bit_end;
   logic                  last_data;
   logic                  expected_par;
   logic [DATA_WIDTH-1:0] bit_sel;

   data_sampling u_sampler (
      .CLK         (CLK),
      .RST         (RST),
      .RX_IN       (RX_IN),
      .prescale    (prescale_reg),
      .edge_count  (edge_count),
      .enable      (enable_reg),
      .sampled_bit (sampled_bit)
   );

   assign bit_end      = enable_reg && (edge_count == (prescale_reg - 6'd1));
   assign last_data    = (bit_count == 4'(DATA_WIDTH));
   assign expected_par = (par_typ_reg == PAR_ODD) ? ~(^data_shift_reg) : (^data_shift_reg);

   // One-hot decode of which shift position the current data bit lands in
   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_sel
         assign bit_sel[gi] = (bit_count == 4'(gi + 1));
      end
   endgenerate

   // Frame FSM with registered outputs; config is frozen at each frame start
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg       <= IDLE;
         enable_reg      <= 1'b0;
         p_data_reg      <= '0;
         data_shift_reg  <= '0;
         data_valid_reg  <= 1'b0;
         par_err_reg     <= 1'b0;
         stp_err_reg     <= 1'b0;
         strt_glitch_reg <= 1'b0;
         par_fail_reg    <= 1'b0;
         stop_fail_reg   <= 1'b0;
         par_en_reg      <= 1'b0;
         par_typ_reg     <= PAR_EVEN;
         prescale_reg    <= PRESCALE_8;
      end else begin
         data_valid_reg  <= 1'b0;
         par_err_reg     <= 1'b0;
         stp_err_reg     <= 1'b0;
         strt_glitch_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               enable_reg <= 1'b0;
               if (!RX_IN) begin
                  state_reg     <= START;
                  enable_reg    <= 1'b1;
                  par_en_reg    <= PAR_EN;
                  par_typ_reg   <= PAR_TYP;
                  prescale_reg  <= legal_prescale(prescale);
                  par_fail_reg  <= 1'b0;
                  stop_fail_reg <= 1'b0;
               end
            end

            START: begin
               if (bit_end) begin
                  if (sampled_bit) begin
                     strt_glitch_reg <= 1'b1;
                     state_reg       <= IDLE;
                     enable_reg      <= 1'b0;
                  end else begin
                     state_reg <= DATA;
                  end
               end
            end

            DATA: begin
               if (bit_end) begin
                  for (int i = 0; i < DATA_WIDTH; i++) begin
                     if (bit_sel[i]) begin
                        data_shift_reg[i] <= sampled_bit;
                     end
                  end
                  if (last_data) begin
                     state_reg <= par_en_reg ? PARITY : STOP;
                  end
               end
            end

            PARITY: begin
               if (bit_end) begin
                  par_fail_reg <= (expected_par != sampled_bit);
                  state_reg    <= STOP;
               end
            end

            STOP: begin
               if (bit_end) begin
                  stop_fail_reg <= ~sampled_bit;
                  state_reg     <= DONE;
                  enable_reg    <= 1'b0;
               end
            end

            DONE: begin
               par_err_reg <= par_fail_reg;
               stp_err_reg <= stop_fail_reg;
               if (!par_fail_reg && !stop_fail_reg) begin
                  data_valid_reg <= 1'b1;
                  p_data_reg     <= data_shift_reg;
               end
               // A low line here is the next start bit, caught one cycle late
               if (!RX_IN) begin
                  state_reg     <= START;
                  enable_reg    <= 1'b1;
                  par_en_reg    <= PAR_EN;
                  par_typ_reg   <= PAR_TYP;
                  prescale_reg  <= legal_prescale(prescale);
                  par_fail_reg  <= 1'b0;
                  stop_fail_reg <= 1'b0;
               end else begin
                  state_reg  <= IDLE;
                  enable_reg <= 1'b0;
               end
            end

            default: begin
               state_reg  <= IDLE;
               enable_reg <= 1'b0;
            end
         endcase
      end
   end

   assign enable      = enable_reg;
   assign P_DATA      = p_data_reg;
   assign data_valid  = data_valid_reg;
   assign par_err     = par_err_reg;
   assign stp_err     = stp_err_reg;
   assign strt_glitch = strt_glitch_reg;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm with an edge/bit counter model and
// an event scoreboard.
module tb_uart_rx_fsm;

   localparam int K_VALID  = 0;
   localparam int K_PAR    = 1;
   localparam int K_STP    = 2;
   localparam int K_GLITCH = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] prescale;
   logic [5:0] edge_count = '0;
   logic [3:0] bit_count  = '0;
   logic       enable;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic       strt_glitch;

   exp_t       sb_q[$];
   exp_t       mon_e;
   logic [3:0] mon_ev;
   logic [3:0] mon_ev_exp;
   logic [7:0] exp_pdata;
   int         n_checks = 0;
   int         n_fail   = 0;

   uart_rx_fsm #(.DATA_WIDTH(8)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_IN       (RX_IN),
      .PAR_EN      (PAR_EN),
      .PAR_TYP     (PAR_TYP),
      .prescale    (prescale),
      .edge_count  (edge_count),
      .bit_count   (bit_count),
      .enable      (enable),
      .P_DATA      (P_DATA),
      .data_valid  (data_valid),
      .par_err     (par_err),
      .stp_err     (stp_err),
      .strt_glitch (strt_glitch)
   );

   always #5 CLK = ~CLK;

   // Edge/bit counter that the receiver expects beside it
   always @(posedge CLK) begin
      if (enable !== 1'b1) begin
         edge_count <= '0;
         bit_count  <= '0;
      end else if (edge_count == prescale - 6'd1) begin
         edge_count <= '0;
         bit_count  <= bit_count + 4'd1;
      end else begin
         edge_count <= edge_count + 6'd1;
      end
   end

   // Scoreboard consumer: every output pulse must match the oldest expectation
   always @(negedge CLK) begin
      if (RST !== 1'b1) begin
         mon_ev = {strt_glitch, stp_err, par_err, data_valid};
         if (mon_ev !== 4'b0000) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: flags(glitch,stp,par,valid)=%b P_DATA=%h, required no event", mon_ev, P_DATA);
            end else begin
               mon_e = sb_q.pop_front();
               mon_ev_exp = 4'b0001 << mon_e.kind;
               if (mon_ev !== mon_ev_exp || P_DATA !== mon_e.data) begin
                  n_fail++;
                  $display("FAIL event: flags=%b P_DATA=%h, required flags=%b P_DATA=%h", mon_ev, P_DATA, mon_ev_exp, mon_e.data);
               end else begin
                  $display("event ok: flags=%b P_DATA=%h at %0t", mon_ev, P_DATA, $time);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input int kind, input logic [7:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit, input logic stop_bit);
      RX_IN = 1'b0;
      repeat (prescale) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RX_IN = d[i];
         repeat (prescale) @(negedge CLK);
      end
      if (with_par) begin
         RX_IN = par_bit;
         repeat (prescale) @(negedge CLK);
      end
      RX_IN = stop_bit;
      repeat (prescale) @(negedge CLK);
      RX_IN = 1'b1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge CLK);
      repeat (6) @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      RX_IN = 1'b1;
      PAR_EN = 1'b0;
      PAR_TYP = 1'b0;
      prescale = 6'd8;
      repeat (3) @(negedge CLK);
      n_checks++;
      if (enable !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_enable: got %b, required 0", enable);
      end
      n_checks++;
      if (P_DATA !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_pdata: got %h, required 00", P_DATA);
      end
      n_checks++;
      if ({strt_glitch, stp_err, par_err, data_valid} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_pulses: got %b, required 0000", {strt_glitch, stp_err, par_err, data_valid});
      end
      RST = 1'b0;
      exp_pdata = 8'h00;
      repeat (4) @(negedge CLK);
      $display("reset done");
   endtask

   task automatic test_prescale8_no_parity();
      prescale = 6'd8;
      PAR_EN = 1'b0;
      exp_pdata = 8'hA5;
      push_exp(K_VALID, exp_pdata);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      wait_drain();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL p8_drain: pending=%0d, required 0", sb_q.size());
      end
   endtask

   task automatic test_parity();
      prescale = 6'd16;
      PAR_EN = 1'b1;
      PAR_TYP = 1'b0;
      repeat (4) @(negedge CLK);
      exp_pdata = 8'h3C;
      push_exp(K_VALID, exp_pdata);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      wait_drain();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL parity_good_drain: pending=%0d, required 0", sb_q.size());
      end
      push_exp(K_PAR, exp_pdata);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      wait_drain();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL parity_bad_drain: pending=%0d, required 0", sb_q.size());
      end
      n_checks++;
      if (P_DATA !== 8'h3C) begin
         n_fail++;
         $display("FAIL parity_hold_pdata: got %h, required 3c", P_DATA);
      end
   endtask

   task automatic test_start_glitch();
      prescale = 6'd8;
      PAR_EN = 1'b0;
      repeat (4) @(negedge CLK);
      push_exp(K_GLITCH, exp_pdata);
      RX_IN = 1'b0;
      repeat (2) @(negedge CLK);
      RX_IN = 1'b1;
      wait_drain();
      n_checks++;
      if (sb_q.size() != 0 || enable !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch2: pending=%0d enable=%b, required 0 and 0", sb_q.size(), enable);
      end
      push_exp(K_GLITCH, exp_pdata);
      RX_IN = 1'b0;
      @(negedge CLK);
      RX_IN = 1'b1;
      wait_drain();
      n_checks++;
      if (sb_q.size() != 0 || enable !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch1: pending=%0d enable=%b, required 0 and 0", sb_q.size(), enable);
      end
   endtask

   task automatic test_stop_error();
      prescale = 6'd8;
      PAR_EN = 1'b0;
      push_exp(K_STP, exp_pdata);
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      wait_drain();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL stop_err_drain: pending=%0d, required 0", sb_q.size());
      end
      n_checks++;
      if (P_DATA !== 8'h3C) begin
         n_fail++;
         $display("FAIL stop_err_hold_pdata: got %h, required 3c", P_DATA);
      end
   endtask

   task automatic test_back_to_back();
      prescale = 6'd32;
      PAR_EN = 1'b0;
      repeat (4) @(negedge CLK);
      push_exp(K_VALID, 8'h01);
      push_exp(K_VALID, 8'hFE);
      exp_pdata = 8'hFE;
      send_frame(8'h01, 1'b0, 1'b0, 1'b1);
      send_frame(8'hFE, 1'b0, 1'b0, 1'b1);
      wait_drain();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: pending=%0d, required 0", sb_q.size());
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      d = 8'h5A;
      prescale = 6'd8;
      PAR_EN = 1'b0;
      repeat (4) @(negedge CLK);
      RX_IN = 1'b0;
      repeat (8) @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         RX_IN = d[i];
         repeat (8) @(negedge CLK);
      end
      RX_IN = d[4];
      repeat (4) @(negedge CLK);
      n_checks++;
      if (enable !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_enable: got %b, required 1", enable);
      end
      RST = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (enable !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_enable: got %b, required 0", enable);
      end
      n_checks++;
      if (P_DATA !== 8'h00) begin
         n_fail++;
         $display("FAIL midreset_pdata: got %h, required 00", P_DATA);
      end
      RST = 1'b0;
      RX_IN = 1'b1;
      exp_pdata = 8'h81;
      repeat (20) @(negedge CLK);
      n_checks++;
      if (enable !== 1'b0) begin
         n_fail++;
         $display("FAIL postreset_idle_enable: got %b, required 0", enable);
      end
      push_exp(K_VALID, 8'h81);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      wait_drain();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL postreset_drain: pending=%0d, required 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_prescale8_no_parity();
      test_parity();
      test_start_glitch();
      test_stop_error();
      test_back_to_back();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
